// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-Lite slave fanned out to NUM_SLAVES APB completers; top HADDR bits pick PSEL, PSLVERR -> 2-cycle ERROR.
// Latency: read 2 / write 3 wait states with zero-wait APB; every PREADY-low cycle adds one more.
// Backpressure: HREADYOUT low while a transfer is in flight; APB_TIMEOUT_EN bounds the ACCESS phase.
module ahb_apb_bridge_mslv #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                               HCLK,
    input  logic                               RESETn,
    input  logic                               HSEL,
    input  logic [ADDR_WIDTH-1:0]              HADDR,
    input  logic [DATA_WIDTH-1:0]              HWDATA,
    input  logic                               HWRITE,
    input  logic [1:0]                         HTRANS,
    input  logic                               HREADY,
    output logic [DATA_WIDTH-1:0]              HRDATA,
    output logic                               HREADYOUT,
    output logic                               HRESP,
    output logic [ADDR_WIDTH-1:0]              PADDR,
    output logic [DATA_WIDTH-1:0]              PWDATA,
    output logic                               PWRITE,
    output logic [NUM_SLAVES-1:0]              PSEL,
    output logic                               PENABLE,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   PRDATA,
    input  logic [NUM_SLAVES-1:0]              PREADY,
    input  logic [NUM_SLAVES-1:0]              PSLVERR
);
    localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 0;
    localparam int IDX_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam logic [IDX_W:0] NUM_S = (IDX_W + 1)'(NUM_SLAVES);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    pwrite_q, pwrite_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;

    logic [IDX_W-1:0]        haddr_idx;
    logic                    idx_ok;
    logic                    start;
    logic                    sel_rdy;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [NUM_SLAVES-1:0]   sel_onehot;
    logic                    tmo_hit;

    if (SEL_BITS > 0) begin : g_idx
        assign haddr_idx = HADDR[ADDR_WIDTH-1 -: IDX_W];
    end else begin : g_idx1
        assign haddr_idx = '0;
    end

    assign idx_ok = ({1'b0, haddr_idx} < NUM_S);
    assign start  = HSEL && HREADY && (HTRANS inside {2'b10, 2'b11});

    // Only the latched completer's response is ever looked at.
    always_comb begin
        sel_rdy    = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdy       = PREADY[i];
                sel_err       = PSLVERR[i];
                sel_rdata     = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_onehot[i] = 1'b1;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_q;

    always_ff @(posedge HCLK or negedge RESETn) begin
        if (!RESETn) begin
            tmo_q <= '0;
        end else if (state_q == ST_SETUP) begin
            tmo_q <= '0;
        end else if (state_q == ST_ACCESS) begin
            tmo_q <= tmo_q + CNT_W'(1);
        end
    end

    assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Constant false: ACCESS waits on PREADY for as long as it takes.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        hrdata_d = hrdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    paddr_d  = HADDR;
                    pwrite_d = HWRITE;
                    idx_d    = haddr_idx;
                    if (!idx_ok) begin
                        state_d = ST_ERR1;
                    end else if (HWRITE) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_WDATA: begin
                pwdata_d = HWDATA;
                state_d  = ST_SETUP;
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_rdy) begin
                    if (sel_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_IDLE;
                        if (!pwrite_q) begin
                            hrdata_d = sel_rdata;
                        end
                    end
                end else if (tmo_hit) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            hrdata_q <= hrdata_d;
        end
    end

    // All AHB/APB handshake outputs decode straight from the state register.
    assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign PSEL      = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? sel_onehot : '0;
    assign PENABLE   = (state_q == ST_ACCESS);
    assign HRDATA    = hrdata_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// Directed bench for ahb_apb_bridge_mslv: transaction-level expected traces checked every cycle,
// plus hand-computed literal checks; a 3-slave instance covers the out-of-range decode.
module tb_ahb_apb_bridge_mslv;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TMO_CYC = 16;
`ifdef APB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic HCLK = 1'b0;
    logic RESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic HSEL, HSEL3, HWRITE, HREADY;
    logic [1:0] HTRANS;
    logic [AW-1:0] HADDR;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic HREADYOUT, HRESP, PWRITE, PENABLE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [NS-1:0] PSEL, PREADY, PSLVERR;
    logic [NS*DW-1:0] PRDATA;

    logic [DW-1:0] h3_hrdata, h3_pwdata;
    logic h3_hreadyout, h3_hresp, h3_pwrite, h3_penable;
    logic [AW-1:0] h3_paddr;
    logic [2:0] h3_psel;
    logic [3*DW-1:0] h3_prdata = '0;
    logic [2:0] h3_pready = 3'b111;
    logic [2:0] h3_pslverr = 3'b000;

    ahb_apb_bridge_mslv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO_CYC)) u_dut (
        .HCLK(HCLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    ahb_apb_bridge_mslv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(3), .TIMEOUT_CYCLES(TMO_CYC)) u_dut3 (
        .HCLK(HCLK), .RESETn(RESETn), .HSEL(HSEL3), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HREADY(HREADY), .HRDATA(h3_hrdata),
        .HREADYOUT(h3_hreadyout), .HRESP(h3_hresp), .PADDR(h3_paddr), .PWDATA(h3_pwdata),
        .PWRITE(h3_pwrite), .PSEL(h3_psel), .PENABLE(h3_penable), .PRDATA(h3_prdata),
        .PREADY(h3_pready), .PSLVERR(h3_pslverr)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    // Expected per-cycle outputs; cycles without an entry must look idle.
    typedef struct {
        int            cyc;
        logic          hro;
        logic          resp;
        logic [NS-1:0] psel;
        logic          pen;
        logic          ck;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t q[$];
    logic [DW-1:0] exp_hrdata = '0;
    logic          rd_pend = 1'b0;
    int            rd_cyc = 0;
    logic [DW-1:0] rd_val = '0;
    logic [DW-1:0] model_pwdata = '0;

    int ws_run = 0, last_ws = 0, pen_run = 0, last_pen = 0, resp_run = 0, last_resp = 0;
    logic [NS-1:0] last_psel = '0;
    logic [AW-1:0] last_paddr = '0;
    logic [DW-1:0] last_pwdata = '0;

    function automatic exp_t mk(input int cy, input logic hro, input logic resp, input logic [NS-1:0] ps,
                                input logic pen, input logic ck, input logic [AW-1:0] a,
                                input logic w, input logic [DW-1:0] d);
        exp_t e;
        e.cyc = cy; e.hro = hro; e.resp = resp; e.psel = ps; e.pen = pen;
        e.ck = ck; e.addr = a; e.wr = w; e.wd = d;
        return e;
    endfunction

    // APB completer behaviour: target answers after tgt_nwait ACCESS cycles, others stay hostile.
    int            tgt_idx = 0;
    int            tgt_nwait = 0;
    logic          tgt_err = 1'b0;
    logic [DW-1:0] tgt_rdata = '0;
    int            acc_cnt = 0;

    initial begin
        PREADY = '1; PSLVERR = '1; PRDATA = '0;
        forever begin
            logic rdy;
            @(negedge HCLK);
            if (PENABLE) begin
                rdy = (acc_cnt == tgt_nwait);
                acc_cnt++;
            end else begin
                rdy = 1'b0;
                acc_cnt = 0;
            end
            for (int i = 0; i < NS; i++) begin
                if (i == tgt_idx) begin
                    PREADY[i]  = rdy;
                    PSLVERR[i] = tgt_err;
                    PRDATA[i*DW +: DW] = rdy ? tgt_rdata : ~tgt_rdata;
                end else begin
                    PREADY[i]  = 1'b1;
                    PSLVERR[i] = 1'b1;
                    PRDATA[i*DW +: DW] = 32'hBAD0_0000 | DW'(i);
                end
            end
        end
    end

    initial forever begin
        @(posedge HCLK);
        cyc++;
    end

    initial forever begin
        exp_t e;
        @(negedge HCLK);
        e = mk(cyc, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
        if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
        if (rd_pend && cyc >= rd_cyc) begin
            exp_hrdata = rd_val;
            rd_pend = 1'b0;
        end
        chk("hreadyout", DW'(HREADYOUT), DW'(e.hro));
        chk("hresp", DW'(HRESP), DW'(e.resp));
        chk("psel", DW'(PSEL), DW'(e.psel));
        chk("penable", DW'(PENABLE), DW'(e.pen));
        chk("hrdata", HRDATA, exp_hrdata);
        if (e.ck) begin
            chk("paddr", DW'(PADDR), DW'(e.addr));
            chk("pwrite", DW'(PWRITE), DW'(e.wr));
            chk("pwdata", PWDATA, e.wd);
        end
        if (!HREADYOUT) ws_run++;
        else if (ws_run > 0) begin last_ws = ws_run; ws_run = 0; end
        if (PENABLE) pen_run++;
        else if (pen_run > 0) begin last_pen = pen_run; pen_run = 0; end
        if (HRESP) resp_run++;
        else if (resp_run > 0) begin last_resp = resp_run; resp_run = 0; end
        if (PSEL != '0) begin
            last_psel = PSEL; last_paddr = PADDR; last_pwdata = PWDATA;
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Called 1ns after a rising edge in an idle cycle; returns in the first idle cycle afterwards.
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                        input int nwait, input logic err, input logic [DW-1:0] rd);
        int c, n, acc, len;
        logic timed_out;
        logic [NS-1:0] oh;
        logic [DW-1:0] pw;
        tgt_idx = int'(addr[AW-1 -: 2]);
        tgt_nwait = nwait; tgt_err = err; tgt_rdata = rd;
        oh = NS'(1) << tgt_idx;
        pw = wr ? wd : model_pwdata;
        if (wr) model_pwdata = wd;
        timed_out = TMO_EN && (nwait >= TMO_CYC);
        acc = timed_out ? TMO_CYC : nwait + 1;
        c = cyc;
        n = c + 1;
        if (wr) begin q.push_back(mk(n, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0)); n++; end
        q.push_back(mk(n, 1'b0, 1'b0, oh, 1'b0, 1'b1, addr, wr, pw)); n++;
        for (int k = 0; k < acc; k++) begin
            q.push_back(mk(n, 1'b0, 1'b0, oh, 1'b1, 1'b1, addr, wr, pw)); n++;
        end
        if (err || timed_out) begin
            q.push_back(mk(n, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0, '0)); n++;
            q.push_back(mk(n, 1'b1, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0, '0)); n++;
        end else if (!wr) begin
            rd_pend = 1'b1; rd_cyc = n; rd_val = rd;
        end
        len = n - c;
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
        tick();
        // Data phase, then a stalled bus presenting junk that must be ignored.
        HWDATA = wd; HREADY = 1'b0; HADDR = ~addr; HWRITE = ~wr;
        for (int k = 0; k < len - 2; k++) begin
            tick();
            HWDATA = ~wd;
        end
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
    endtask

    logic [AW-1:0] b_addr [4] = '{8'h00, 8'h00, 8'hFF, 8'h7C};
    logic          b_wr   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] b_wd   [4] = '{32'h0000_1111, 32'h0, 32'h5555_AAAA, 32'h0};
    int            b_nw   [4] = '{1, 0, 3, 1};
    logic          b_err  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] b_rd   [4] = '{32'h0, 32'h600D_F00D, 32'h0, 32'h7C7C_0001};

    initial begin
        int c;
        HSEL = 1'b0; HSEL3 = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
        HTRANS = 2'b00; HREADY = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 RESETn = 1'b1;
        chk("rst_hreadyout", DW'(HREADYOUT), 32'd1);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_psel", DW'(PSEL), 32'd0);
        chk("rst_paddr", DW'(PADDR), 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);

        xfer(8'h45, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'h0);
        @(negedge HCLK); #1;
        chk("wr_psel", DW'(last_psel), 32'h2);
        chk("wr_paddr", DW'(last_paddr), 32'h45);
        chk("wr_pwdata", last_pwdata, 32'hDEADBEEF);
        chk("wr_waits", DW'(last_ws), 32'd3);
        tick();

        xfer(8'hC4, 1'b0, 32'h0, 2, 1'b0, 32'h12345678);
        @(negedge HCLK); #1;
        chk("rd_penable_cycles", DW'(last_pen), 32'd3);
        chk("rd_waits", DW'(last_ws), 32'd4);
        chk("rd_hrdata", HRDATA, 32'h12345678);
        tick();

        xfer(8'h10, 1'b0, 32'h0, 0, 1'b1, 32'h0F0F0F0F);
        @(negedge HCLK); #1;
        chk("err_resp_cycles", DW'(last_resp), 32'd2);
        chk("err_waits", DW'(last_ws), 32'd3);
        chk("err_hrdata_held", HRDATA, 32'h12345678);
        tick();

        for (int i = 0; i < 4; i++) xfer(b_addr[i], b_wr[i], b_wd[i], b_nw[i], b_err[i], b_rd[i]);
        tick();

        HSEL3 = 1'b1; HADDR = 8'hC0; HWRITE = 1'b0; HTRANS = 2'b10; HREADY = 1'b1;
        tick();
        HSEL3 = 1'b0; HTRANS = 2'b00;
        #3;
        chk("bad_err1_resp", DW'(h3_hresp), 32'd1);
        chk("bad_err1_ready", DW'(h3_hreadyout), 32'd0);
        chk("bad_err1_psel", DW'(h3_psel), 32'd0);
        tick(); #3;
        chk("bad_err2_resp", DW'(h3_hresp), 32'd1);
        chk("bad_err2_ready", DW'(h3_hreadyout), 32'd1);
        chk("bad_err2_psel", DW'(h3_psel), 32'd0);
        tick(); #3;
        chk("bad_idle_resp", DW'(h3_hresp), 32'd0);
        chk("bad_idle_ready", DW'(h3_hreadyout), 32'd1);
        tick();

        // Reset in the middle of a stalled read on slave 2.
        c = cyc;
        tgt_idx = 2; tgt_nwait = 1000; tgt_err = 1'b0; tgt_rdata = 32'h0;
        q.push_back(mk(c + 1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 8'h80, 1'b0, model_pwdata));
        for (int k = 2; k <= 4; k++) q.push_back(mk(c + k, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h80, 1'b0, model_pwdata));
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HADDR = 8'h80; HWRITE = 1'b0;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        repeat (4) tick();
        #1 RESETn = 1'b0;
        q.delete(); exp_hrdata = '0; rd_pend = 1'b0; model_pwdata = '0;
        #1;
        chk("rst_mid_psel", DW'(PSEL), 32'd0);
        chk("rst_mid_penable", DW'(PENABLE), 32'd0);
        chk("rst_mid_hreadyout", DW'(HREADYOUT), 32'd1);
        repeat (2) tick();
        RESETn = 1'b1;
        xfer(8'h20, 1'b1, 32'hCAFEF00D, 1, 1'b0, 32'h0);
        @(negedge HCLK); #1;
        chk("post_rst_pwdata", last_pwdata, 32'hCAFEF00D);
        chk("post_rst_psel", DW'(last_psel), 32'h1);
        tick();

`ifdef APB_TIMEOUT_EN
        xfer(8'h80, 1'b0, 32'h0, 1000, 1'b0, 32'h11112222);
        @(negedge HCLK); #1;
        chk("tmo_penable_cycles", DW'(last_pen), 32'd16);
        chk("tmo_resp_cycles", DW'(last_resp), 32'd2);
        chk("tmo_hrdata_held", HRDATA, 32'd0);
        tick();
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
